divider_wb_unit: RTL and testbench

Iterative RV32M divide/remainder unit that sits beside the single-cycle datapath and produces register-file writebacks. It accepts one DIV/DIVU/REM/REMU operation, computes it over WIDTH cycles with a restoring shift-subtract algorithm, and then drives one write-port transaction (we3/wa3/wd3) into the register file. It is the producer side of the register file's synchronous write port. Control logic stalls the PC while `busy` is high.

---
 rtl/divider_wb_unit.sv | 146 ++++++++++++++
 tb/tb_divider_wb_unit.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/divider_wb_unit.sv
// Iterative RV32M DIV/DIVU/REM/REMU unit using restoring shift-subtract division.
// Produces a single register-file writeback (we3/wa3/wd3) a fixed WIDTH+1 cycles after accept.
module divider_wb_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] rs1_val,
    input  logic [WIDTH-1:0] rs2_val,
    input  logic [4:0]       rd,
    output logic             busy,
    output logic             wb_we,
    output logic [4:0]       wb_addr,
    output logic [WIDTH-1:0] wb_data
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        WB
    } state_t;

    state_t state, state_nxt;

    logic [1:0]       op_q;
    logic [4:0]       rd_q;
    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] dvs_q;
    logic [WIDTH:0]   rem_q;
    logic [WIDTH-1:0] orig_q;
    logic             qsign_q;
    logic             rsign_q;
    logic             dbz_q;
    logic [CW-1:0]    cnt;

    logic             last_iter;
    logic             is_signed;
    logic             s1;
    logic             s2;
    logic [WIDTH-1:0] abs1;
    logic [WIDTH-1:0] abs2;
    logic [WIDTH:0]   r_shift;
    logic             ge;
    logic [WIDTH:0]   r_nxt;
    logic [WIDTH-1:0] q_nxt;
    logic [WIDTH-1:0] quo_fix;
    logic [WIDTH-1:0] rem_fix;
    logic [WIDTH-1:0] result;

    assign busy      = (state != IDLE);
    assign last_iter = (cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = CALC;
            CALC:    if (last_iter) state_nxt = WB;
            WB:      state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Operand magnitudes at accept, one restoring step, and the final sign/div-by-zero selection.
    always_comb begin
        is_signed = ~op[0];
        s1        = is_signed & rs1_val[WIDTH-1];
        s2        = is_signed & rs2_val[WIDTH-1];
        abs1      = s1 ? (~rs1_val + 1'b1) : rs1_val;
        abs2      = s2 ? (~rs2_val + 1'b1) : rs2_val;

        r_shift   = {rem_q[WIDTH-1:0], quo_q[WIDTH-1]};
        ge        = (r_shift >= {1'b0, dvs_q});
        r_nxt     = ge ? (r_shift - {1'b0, dvs_q}) : r_shift;
        q_nxt     = {quo_q[WIDTH-2:0], ge};

        quo_fix   = (~op_q[0] & qsign_q) ? (~q_nxt + 1'b1) : q_nxt;
        rem_fix   = (~op_q[0] & rsign_q) ? (~r_nxt[WIDTH-1:0] + 1'b1) : r_nxt[WIDTH-1:0];

        if (dbz_q) begin
            result = op_q[1] ? orig_q : {WIDTH{1'b1}};
        end else begin
            result = op_q[1] ? rem_fix : quo_fix;
        end
    end

    // Datapath and writeback registers; wb_we defaults low so it pulses only for the WB cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_q    <= '0;
            rd_q    <= '0;
            quo_q   <= '0;
            dvs_q   <= '0;
            rem_q   <= '0;
            orig_q  <= '0;
            qsign_q <= 1'b0;
            rsign_q <= 1'b0;
            dbz_q   <= 1'b0;
            cnt     <= '0;
            wb_we   <= 1'b0;
            wb_addr <= '0;
            wb_data <= '0;
        end else begin
            wb_we <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        op_q    <= op;
                        rd_q    <= rd;
                        quo_q   <= abs1;
                        dvs_q   <= abs2;
                        rem_q   <= '0;
                        orig_q  <= rs1_val;
                        qsign_q <= s1 ^ s2;
                        rsign_q <= s1;
                        dbz_q   <= (rs2_val == '0);
                        cnt     <= '0;
                    end
                end
                CALC: begin
                    rem_q <= r_nxt;
                    quo_q <= q_nxt;
                    cnt   <= cnt + 1'b1;
                    if (last_iter) begin
                        wb_we   <= (rd_q != 5'd0);
                        wb_addr <= rd_q;
                        wb_data <= result;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_divider_wb_unit.sv
// Scoreboard bench for divider_wb_unit: expected writebacks are queued on accept
// and compared, with their latency, whenever the DUT strobes wb_we.
module tb_divider_wb_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic [4:0]  rd;
    logic        busy;
    logic        wb_we;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] data;
        int          acc;
    } exp_t;

    exp_t sb[$];

    divider_wb_unit #(.WIDTH(32)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .op      (op),
        .rs1_val (rs1_val),
        .rs2_val (rs2_val),
        .rd      (rd),
        .busy    (busy),
        .wb_we   (wb_we),
        .wb_addr (wb_addr),
        .wb_data (wb_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        logic signed [31:0] sa;
        logic signed [31:0] sb_;
        sa  = a;
        sb_ = b;
        if (b == 32'd0) return o[1] ? a : 32'hFFFF_FFFF;
        case (o)
            2'b00:   return (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? 32'h8000_0000 : 32'(sa / sb_);
            2'b01:   return a / b;
            2'b10:   return (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? 32'd0 : 32'(sa % sb_);
            default: return a % b;
        endcase
    endfunction

    // Write monitor: every strobe must match the oldest queued expectation.
    always @(negedge clk) begin
        if (wb_we) begin
            if (sb.size() == 0) begin
                checkOutput("unexpected_wb", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                checkOutput("wb_addr", 32'(wb_addr), 32'(e.addr));
                checkOutput("wb_data", wb_data, e.data);
                checkOutput("latency", 32'(cyc - e.acc), 32'd32);
            end
        end
    end

    task automatic applyStimulus(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                 input logic [4:0] r, input logic [31:0] exp, input bit push);
        @(negedge clk);
        start   = 1'b1;
        op      = o;
        rs1_val = a;
        rs2_val = b;
        rd      = r;
        if (push) sb.push_back('{addr: r, data: exp, acc: cyc + 1});
        @(posedge clk);
        @(negedge clk);
        start   = 1'b0;
        rs1_val = $urandom;
        rs2_val = $urandom;
        rd      = 5'($urandom);
        op      = 2'($urandom);
    endtask

    // Count busy cycles and write pulses of one op; optionally poke start during CALC and WB.
    task automatic runOp(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] r, input logic [31:0] exp, input bit poke);
        int busyCnt;
        int pulses;
        busyCnt = 0;
        pulses  = 0;
        applyStimulus(o, a, b, r, exp, r != 5'd0);
        while (busy && busyCnt < 100) begin
            busyCnt++;
            if (wb_we) pulses++;
            if (poke && (busyCnt == 5 || busyCnt == 33)) begin
                start   = 1'b1;
                op      = 2'b01;
                rs1_val = 32'd77;
                rs2_val = 32'd3;
                rd      = 5'd21;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
        checkOutput("busy_cycles", 32'(busyCnt), 32'd33);
        checkOutput("wb_pulses", 32'(pulses), (r != 5'd0) ? 32'd1 : 32'd0);
    endtask

    initial begin
        int pulses;
        int busyCnt;
        rst     = 1'b1;
        start   = 1'b0;
        op      = 2'b00;
        rs1_val = '0;
        rs2_val = '0;
        rd      = '0;
        repeat (3) @(negedge clk);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_wb_we", 32'(wb_we), 32'd0);
        checkOutput("rst_wb_addr", 32'(wb_addr), 32'd0);
        checkOutput("rst_wb_data", wb_data, 32'd0);
        rst = 1'b0;

        runOp(2'b01, 32'd100, 32'd7, 5'd5, 32'd14, 1'b0);
        runOp(2'b10, 32'hFFFF_FFF9, 32'd2, 5'd6, 32'hFFFF_FFFF, 1'b0);
        runOp(2'b00, 32'hFFFF_FFF9, 32'd2, 5'd7, 32'hFFFF_FFFD, 1'b0);
        runOp(2'b11, 32'hFFFF_FFF9, 32'd2, 5'd8, 32'd1, 1'b0);
        runOp(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 5'd9, 32'h8000_0000, 1'b0);
        runOp(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10, 32'd0, 1'b0);
        runOp(2'b00, 32'hFFFF_FFFB, 32'd0, 5'd11, 32'hFFFF_FFFF, 1'b0);
        runOp(2'b10, 32'hFFFF_FFFB, 32'd0, 5'd12, 32'hFFFF_FFFB, 1'b0);
        runOp(2'b01, 32'd9, 32'd0, 5'd13, 32'hFFFF_FFFF, 1'b0);
        runOp(2'b11, 32'd9, 32'd0, 5'd14, 32'd9, 1'b0);
        runOp(2'b01, 32'd1000, 32'd10, 5'd15, 32'd100, 1'b1);
        runOp(2'b00, 32'd20, 32'd3, 5'd0, 32'd6, 1'b0);

        // Reset at the 10th CALC cycle must kill the op without any write.
        applyStimulus(2'b01, 32'd123, 32'd4, 5'd16, 32'd30, 1'b0);
        busyCnt = 1;
        while (busy && busyCnt < 10) begin
            busyCnt++;
            @(negedge clk);
        end
        rst = 1'b1;
        @(negedge clk);
        checkOutput("rst_mid_busy", 32'(busy), 32'd0);
        checkOutput("rst_mid_wb_we", 32'(wb_we), 32'd0);
        rst = 1'b0;
        pulses = 0;
        repeat (40) begin
            @(negedge clk);
            if (wb_we || busy) pulses++;
        end
        checkOutput("rst_no_write", 32'(pulses), 32'd0);
        runOp(2'b01, 32'd50, 32'd5, 5'd17, 32'd10, 1'b0);

        for (int i = 0; i < 8; i++) begin
            logic [1:0]  o;
            logic [31:0] a;
            logic [31:0] b;
            o = 2'($urandom);
            a = $urandom;
            b = (i < 4) ? 32'($urandom_range(1, 1000)) : $urandom;
            if (i == 7) b = 32'hFFFF_FFFF;
            runOp(o, a, b, 5'(i + 20), model(o, a, b), 1'b0);
        end

        repeat (2) @(negedge clk);
        checkOutput("sb_empty", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
